// File: rtl/jtframe_romrq_resp_if.sv
// Client-side ROM request bus and SDRAM read-port signals for jtframe_romrq_resp.
// The master modport belongs to the clients and the back end; the slave modport belongs to the responder.
interface jtframe_romrq_resp_if #(
    parameter int CLIENTS = 4,
    parameter int SDRAMW  = 22
);
    logic [CLIENTS-1:0]        req;
    logic [CLIENTS*SDRAMW-1:0] addr;
    logic [CLIENTS-1:0]        we;
    logic [CLIENTS-1:0]        dst;
    logic [CLIENTS-1:0]        din_ok;
    logic [15:0]               dout;
    logic                      mem_req;
    logic [SDRAMW-1:0]         mem_addr;
    logic                      mem_ack;
    logic [15:0]               mem_din;
    logic                      mem_dok;
    logic                      busy;

    modport master (
        output req, addr, mem_ack, mem_din, mem_dok,
        input  we, dst, din_ok, dout, mem_req, mem_addr, busy
    );

    modport slave (
        input  req, addr, mem_ack, mem_din, mem_dok,
        output we, dst, din_ok, dout, mem_req, mem_addr, busy
    );
endinterface

// File: rtl/jtframe_romrq_resp.sv
// Round-robin responder serving 2-word SDRAM read bursts to up to four ROM-request clients.
// CLIENTS/SDRAMW must match the parameters of the connected interface instance.
module jtframe_romrq_resp #(
    parameter int CLIENTS = 4,
    parameter int SDRAMW  = 22
) (
    input  logic                 clk,
    input  logic                 rst,
    jtframe_romrq_resp_if.slave  bus
);
    localparam int PW = (CLIENTS > 1) ? $clog2(CLIENTS) : 1;

    typedef enum logic [2:0] {IDLE, ISSUE, WORD0, WORD1, GAP} state_t;

    state_t              state, state_nx;
    logic [PW-1:0]       ptr, ptr_nx;
    logic [CLIENTS-1:0]  we_r, we_nx;
    logic [CLIENTS-1:0]  dst_r, dst_nx;
    logic [CLIENTS-1:0]  din_ok_r, din_ok_nx;
    logic [15:0]         dout_r, dout_nx;
    logic                mem_req_r, mem_req_nx;
    logic [SDRAMW-1:0]   mem_addr_r, mem_addr_nx;
    logic                found;
    int                  gidx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            ptr        <= '0;
            we_r       <= '0;
            dst_r      <= '0;
            din_ok_r   <= '0;
            dout_r     <= '0;
            mem_req_r  <= 1'b0;
            mem_addr_r <= '0;
        end else begin
            state      <= state_nx;
            ptr        <= ptr_nx;
            we_r       <= we_nx;
            dst_r      <= dst_nx;
            din_ok_r   <= din_ok_nx;
            dout_r     <= dout_nx;
            mem_req_r  <= mem_req_nx;
            mem_addr_r <= mem_addr_nx;
        end
    end

    always_comb begin
        state_nx    = state;
        ptr_nx      = ptr;
        we_nx       = we_r;
        dst_nx      = '0;
        din_ok_nx   = '0;
        dout_nx     = dout_r;
        mem_req_nx  = mem_req_r;
        mem_addr_nx = mem_addr_r;
        found       = 1'b0;
        gidx        = 0;

        // first requester at or after the pointer, wrapping inside the populated range
        for (int k = 0; k < CLIENTS; k++) begin
            if (!found && bus.req[(int'(ptr) + k) % CLIENTS]) begin
                found = 1'b1;
                gidx  = (int'(ptr) + k) % CLIENTS;
            end
        end

        case (state)
            IDLE: begin
                if (found) begin
                    we_nx       = CLIENTS'(1) << gidx;
                    mem_req_nx  = 1'b1;
                    mem_addr_nx = bus.addr[gidx*SDRAMW +: SDRAMW];
                    ptr_nx      = PW'((gidx + 1) % CLIENTS);
                    state_nx    = ISSUE;
                end
            end
            ISSUE: begin
                if (bus.mem_ack) begin
                    mem_req_nx = 1'b0;
                    // a data word arriving with the ack is the first word of the burst
                    if (bus.mem_dok) begin
                        dout_nx   = bus.mem_din;
                        dst_nx    = we_r;
                        din_ok_nx = we_r;
                        state_nx  = WORD1;
                    end else begin
                        state_nx  = WORD0;
                    end
                end
            end
            WORD0: begin
                if (bus.mem_dok) begin
                    dout_nx   = bus.mem_din;
                    dst_nx    = we_r;
                    din_ok_nx = we_r;
                    state_nx  = WORD1;
                end
            end
            WORD1: begin
                if (bus.mem_dok) begin
                    dout_nx   = bus.mem_din;
                    din_ok_nx = we_r;
                    state_nx  = GAP;
                end
            end
            GAP: begin
                we_nx    = '0;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign bus.we       = we_r;
    assign bus.dst      = dst_r;
    assign bus.din_ok   = din_ok_r;
    assign bus.dout     = dout_r;
    assign bus.mem_req  = mem_req_r;
    assign bus.mem_addr = mem_addr_r;
    assign bus.busy     = (state != IDLE);
endmodule

// File: tb/tb_jtframe_romrq_resp.sv
// Directed bench for jtframe_romrq_resp: a back-end model pushes expected client words
// into a scoreboard, and a monitor pops them when din_ok fires.
module tb_jtframe_romrq_resp;
    localparam int CLIENTS = 4;
    localparam int SDRAMW  = 22;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   last_dok = 0;
    int   prev_dok = 0;

    typedef struct {
        logic [3:0]  mask;
        logic        first;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    localparam logic [SDRAMW-1:0] A0 = 22'h012345;
    localparam logic [SDRAMW-1:0] A1 = 22'h02A000;
    localparam logic [SDRAMW-1:0] A2 = 22'h3FFFFF;
    localparam logic [SDRAMW-1:0] A3 = 22'h000001;

    jtframe_romrq_resp_if #(.CLIENTS(CLIENTS), .SDRAMW(SDRAMW)) bus ();

    jtframe_romrq_resp #(.CLIENTS(CLIENTS), .SDRAMW(SDRAMW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // strobe monitor: every din_ok must match the next scoreboard entry
    always @(negedge clk) begin
        if (!rst) begin
            chk("strobe_in_we", 32'((bus.dst | bus.din_ok) & ~bus.we), 32'd0);
            chk("we_onehot", 32'($countones(bus.we) > 1), 32'd0);
            chk("dst_with_dok", 32'(bus.dst & ~bus.din_ok), 32'd0);
            if (bus.din_ok != '0) begin
                if (sb.size() == 0) begin
                    chk("stray_din_ok", 32'(bus.din_ok), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("din_ok_mask", 32'(bus.din_ok), 32'(e.mask));
                    chk("dst_mask", 32'(bus.dst), e.first ? 32'(e.mask) : 32'd0);
                    chk("dout", 32'(bus.dout), 32'(e.data));
                end
                prev_dok <= last_dok;
                last_dok <= cyc;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req();
        int n;
        n = 0;
        while (bus.mem_req !== 1'b1 && n < 50) begin
            step();
            n++;
        end
        chk("mem_req_timeout", 32'(n < 50), 32'd1);
    endtask

    task automatic hold(input logic [3:0] m);
        step();
        chk("we_hold", 32'(bus.we), 32'(m));
        chk("busy_hold", 32'(bus.busy), 32'd1);
    endtask

    // back-end burst for the expected client; returns at the GAP cycle
    task automatic burst(input int client, input logic [SDRAMW-1:0] a,
                         input logic [15:0] w0, input logic [15:0] w1,
                         input int ack_lat, input int word_lat,
                         input bit merge, input bit stray);
        logic [3:0] m;
        m = 4'b0001 << client;
        wait_req();
        chk("mem_addr", 32'(bus.mem_addr), 32'(a));
        chk("we_grant", 32'(bus.we), 32'(m));
        chk("busy_grant", 32'(bus.busy), 32'd1);
        for (int i = 0; i < ack_lat; i++) begin
            if (stray) begin
                bus.mem_dok = 1'b1;
                bus.mem_din = 16'hDEAD;
            end
            hold(m);
            bus.mem_dok = 1'b0;
            chk("mem_req_held", 32'(bus.mem_req), 32'd1);
        end
        bus.mem_ack = 1'b1;
        if (merge) begin
            bus.mem_dok = 1'b1;
            bus.mem_din = w0;
            sb.push_back('{mask: m, first: 1'b1, data: w0});
        end
        step();
        bus.mem_ack = 1'b0;
        bus.mem_dok = 1'b0;
        chk("mem_req_drop", 32'(bus.mem_req), 32'd0);
        if (!merge) begin
            for (int i = 0; i < word_lat; i++) hold(m);
            bus.mem_dok = 1'b1;
            bus.mem_din = w0;
            sb.push_back('{mask: m, first: 1'b1, data: w0});
            step();
            bus.mem_dok = 1'b0;
        end
        for (int i = 0; i < word_lat; i++) hold(m);
        bus.mem_dok = 1'b1;
        bus.mem_din = w1;
        sb.push_back('{mask: m, first: 1'b0, data: w1});
        step();
        bus.mem_dok = 1'b0;
        chk("busy_gap", 32'(bus.busy), 32'd1);
        chk("we_gap", 32'(bus.we), 32'(m));
    endtask

    task automatic to_idle(input logic [3:0] next_req);
        bus.req = next_req;
        step();
        chk("idle_we", 32'(bus.we), 32'd0);
        chk("idle_busy", 32'(bus.busy), 32'd0);
    endtask

    task automatic check_reset_outputs();
        chk("rst_we", 32'(bus.we), 32'd0);
        chk("rst_dst", 32'(bus.dst), 32'd0);
        chk("rst_din_ok", 32'(bus.din_ok), 32'd0);
        chk("rst_dout", 32'(bus.dout), 32'd0);
        chk("rst_mem_req", 32'(bus.mem_req), 32'd0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd0);
    endtask

    initial begin
        rst         = 1'b1;
        bus.req     = '0;
        bus.addr    = {A3, A2, A1, A0};
        bus.mem_ack = 1'b0;
        bus.mem_dok = 1'b0;
        bus.mem_din = '0;
        step();
        step();
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b0;

        // single client 0
        bus.req = 4'b0001;
        burst(0, A0, 16'hAAAA, 16'hBBBB, 2, 1, 1'b0, 1'b0);
        to_idle(4'b0000);

        // three clients held: 0,1,2,0 with one idle cycle between bursts
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.req = 4'b0111;
        burst(0, A0, 16'h1000, 16'h1001, 0, 1, 1'b0, 1'b0);
        to_idle(4'b0111);
        step();
        chk("regrant_next", 32'(bus.mem_req), 32'd1);
        burst(1, A1, 16'h1100, 16'h1101, 1, 0, 1'b0, 1'b0);
        to_idle(4'b0111);
        step();
        chk("regrant_next", 32'(bus.mem_req), 32'd1);
        burst(2, A2, 16'h1200, 16'h1201, 0, 2, 1'b0, 1'b0);
        to_idle(4'b0111);
        step();
        chk("regrant_next", 32'(bus.mem_req), 32'd1);
        burst(0, A0, 16'h1300, 16'h1301, 1, 1, 1'b0, 1'b0);
        to_idle(4'b0000);

        // pointer wrap: 3, then 0, then 1
        bus.req = 4'b1000;
        burst(3, A3, 16'h3333, 16'h3334, 1, 1, 1'b0, 1'b0);
        to_idle(4'b0011);
        burst(0, A0, 16'h4000, 16'h4001, 1, 1, 1'b0, 1'b0);
        to_idle(4'b0010);
        burst(1, A1, 16'h4100, 16'h4101, 1, 1, 1'b0, 1'b0);
        to_idle(4'b0000);

        // zero-latency: ack, word0, word1 on consecutive cycles
        bus.req = 4'b0100;
        burst(2, A2, 16'h5A5A, 16'hA5A5, 0, 0, 1'b0, 1'b0);
        to_idle(4'b0000);
        chk("dok_back_to_back", 32'(last_dok - prev_dok), 32'd1);

        // ack together with word0, word1 next cycle
        bus.req = 4'b0001;
        burst(0, A0, 16'h0F0F, 16'hF0F0, 0, 0, 1'b1, 1'b0);
        to_idle(4'b0000);
        chk("dok_merged", 32'(last_dok - prev_dok), 32'd1);

        // slow back end with stray mem_dok while waiting for ack
        bus.req = 4'b1000;
        burst(3, A3, 16'hC0DE, 16'hBEEF, 3, 10, 1'b0, 1'b1);
        to_idle(4'b0000);

        // reset while waiting for word 1
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.req = 4'b0001;
        wait_req();
        chk("r6_mem_addr", 32'(bus.mem_addr), 32'(A0));
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0;
        bus.mem_dok = 1'b1;
        bus.mem_din = 16'h6000;
        sb.push_back('{mask: 4'b0001, first: 1'b1, data: 16'h6000});
        step();
        bus.mem_dok = 1'b0;
        bus.req = 4'b0000;
        step();
        chk("r6_in_word1", 32'(bus.we), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs();
        @(negedge clk);
        rst = 1'b0;
        bus.mem_dok = 1'b1;
        bus.mem_din = 16'h6001;
        step();
        bus.mem_dok = 1'b0;
        step();
        step();
        chk("r6_stray_idle", 32'(bus.busy), 32'd0);
        bus.req = 4'b0010;
        burst(1, A1, 16'h7000, 16'h7001, 1, 1, 1'b0, 1'b0);
        to_idle(4'b0000);
        step();
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
